// File: rtl/wb_burst_arbiter2_if.sv
// Wishbone point-to-point bundle: request fields from master, response fields from slave.
// Combinational wires only, no latency.
// Backpressure is the classic stb/ack handshake carried by these signals.
interface wb_burst_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_burst_arbiter2.sv
// Two-master round-robin Wishbone arbiter with per-cycle grant hold and stall watchdog.
// Latency: one cycle from cyc rising in IDLE to wbs cyc; one dead cycle on handover.
// Backpressure: owner sees the slave ack directly; a stalled cycle is aborted with err.
module wb_burst_arbiter2 #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_burst_arbiter2_if.slave   wbm0,
  wb_burst_arbiter2_if.slave   wbm1,
  wb_burst_arbiter2_if.master  wbs,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_EN  = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t          state_d, state_q;
  logic            last_grant_d, last_grant_q;
  logic [CW-1:0]   wdog_d, wdog_q;
  logic            abort_d, abort_q;

  logic            owner_cyc, owner_stb, expire;
  logic            ack_resp, err_resp;
  logic [WB_AW-1:0]   adr_mux;
  logic [WB_DW-1:0]   dat_mux;
  logic [WB_DW/8-1:0] sel_mux;
  logic [2:0]      cti_mux;
  logic [1:0]      bte_mux;
  logic            we_mux, cyc_mux, stb_mux;

  // State, round-robin history, watchdog counter and abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      abort_q      <= abort_d;
    end
  end

  // Grant selection: ties broken against the previous owner, grant held until owner drops cyc
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (wbm0.cyc && (!wbm1.cyc || last_grant_q)) state_d = GNT0;
        else if (wbm1.cyc)                           state_d = GNT1;
      end
      GNT0: if (!wbm0.cyc) state_d = wbm1.cyc ? GNT1 : IDLE;
      GNT1: if (!wbm1.cyc) state_d = wbm0.cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GNT0)      last_grant_d = 1'b0;
      else if (state_d == GNT1) last_grant_d = 1'b1;
    end
  end

  // Bus mux, response routing and watchdog next-state
  always_comb begin
    adr_mux   = wbm0.adr;
    dat_mux   = wbm0.dat_w;
    sel_mux   = wbm0.sel;
    cti_mux   = wbm0.cti;
    bte_mux   = wbm0.bte;
    we_mux    = 1'b0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    if (state_q == GNT1) begin
      adr_mux = wbm1.adr;
      dat_mux = wbm1.dat_w;
      sel_mux = wbm1.sel;
      cti_mux = wbm1.cti;
      bte_mux = wbm1.bte;
      we_mux  = wbm1.we;
      owner_cyc = wbm1.cyc;
      owner_stb = wbm1.stb;
    end else if (state_q == GNT0) begin
      we_mux  = wbm0.we;
      owner_cyc = wbm0.cyc;
      owner_stb = wbm0.stb;
    end
    // An aborted cycle stays off the slave bus until the owner gives up
    cyc_mux = owner_cyc && !abort_q;
    stb_mux = owner_stb && !abort_q;

    // A real ack or err in the expiry cycle takes priority over the abort
    expire = WD_EN && (state_q != IDLE) && !abort_q && owner_stb &&
             !wbs.ack && !wbs.err && (wdog_q == WD_MAX);
    ack_resp = !abort_q && wbs.ack;
    err_resp = !abort_q && (wbs.err || expire);

    wdog_d = wdog_q;
    if (!WD_EN || (state_d != state_q) || abort_q || !owner_stb || wbs.ack || wbs.err)
      wdog_d = '0;
    else if (wdog_q != WD_MAX)
      wdog_d = wdog_q + CW'(1);

    abort_d = abort_q;
    if (expire)                    abort_d = 1'b1;
    else if (abort_q && !owner_cyc) abort_d = 1'b0;
  end

  assign wbs.adr   = adr_mux;
  assign wbs.dat_w = dat_mux;
  assign wbs.sel   = sel_mux;
  assign wbs.cti   = cti_mux;
  assign wbs.bte   = bte_mux;
  assign wbs.we    = we_mux;
  assign wbs.cyc   = cyc_mux;
  assign wbs.stb   = stb_mux;

  assign wbm0.dat_r = wbs.dat_r;
  assign wbm1.dat_r = wbs.dat_r;
  assign wbm0.ack   = (state_q == GNT0) && ack_resp;
  assign wbm0.err   = (state_q == GNT0) && err_resp;
  assign wbm1.ack   = (state_q == GNT1) && ack_resp;
  assign wbm1.err   = (state_q == GNT1) && err_resp;

  assign grant_o   = {state_q == GNT1, state_q == GNT0};
  assign timeout_o = expire;

endmodule

// File: tb/tb_wb_burst_arbiter2.sv
// Directed bench for wb_burst_arbiter2: arbitration, burst hold, watchdog abort, reset.
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Slave responses are driven by hand from the bench.
module tb_wb_burst_arbiter2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;
  int         checks   = 0;
  int         failures = 0;
  int         beats;

  wb_burst_arbiter2_if #(.AW(32), .DW(32)) m0_if ();
  wb_burst_arbiter2_if #(.AW(32), .DW(32)) m1_if ();
  wb_burst_arbiter2_if #(.AW(32), .DW(32)) s_if ();

  wb_burst_arbiter2 #(.WB_AW(32), .WB_DW(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbm0      (m0_if.slave),
    .wbm1      (m1_if.slave),
    .wbs       (s_if.master),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = 4'hf; m0_if.we = 1'b0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.cti = 3'b000; m0_if.bte = 2'b00;
    m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = 4'hf; m1_if.we = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.cti = 3'b000; m1_if.bte = 2'b00;
    s_if.dat_r = '0; s_if.ack = 1'b0; s_if.err = 1'b0;

    // reset state
    tk(); tk(); smp();
    check("rst_cyc", s_if.cyc, 0);
    check("rst_stb", s_if.stb, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_timeout", timeout, 0);
    check("rst_m0_ack", m0_if.ack, 0);
    check("rst_m1_err", m1_if.err, 0);

    // 1: m0 classic read, ack after two wait cycles
    tk(); rst = 1'b0;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
    smp(); check("t1_cyc_same_cycle", s_if.cyc, 0); check("t1_grant_idle", grant, 2'b00);
    tk(); smp();
    check("t1_cyc_next", s_if.cyc, 1); check("t1_grant", grant, 2'b01);
    check("t1_adr", s_if.adr, 32'h100); check("t1_no_ack_w1", m0_if.ack, 0);
    tk(); smp(); check("t1_no_ack_w2", m0_if.ack, 0);
    tk(); s_if.ack = 1; s_if.dat_r = 32'hCAFE0001;
    smp();
    check("t1_ack", m0_if.ack, 1); check("t1_dat", m0_if.dat_r, 32'hCAFE0001);
    check("t1_m1_ack", m1_if.ack, 0); check("t1_m1_dat_bcast", m1_if.dat_r, 32'hCAFE0001);
    tk(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    smp(); check("t1_ack_1cyc", m0_if.ack, 0); check("t1_cyc_drop", s_if.cyc, 0);
    tk(); smp(); check("t1_grant_done", grant, 2'b00);

    // 2: simultaneous requests from reset, alternation with one dead cycle
    tk(); rst = 1'b1;
    tk(); rst = 1'b0;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h200;
    smp(); check("t2_idle", grant, 2'b00);
    tk(); smp(); check("t2_m0_first", grant, 2'b01); check("t2_adr0", s_if.adr, 32'h100);
    tk(); s_if.ack = 1;
    smp(); check("t2_m0_ack", m0_if.ack, 1); check("t2_m1_no_ack", m1_if.ack, 0);
    tk(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    smp(); check("t2_dead_cyc", s_if.cyc, 0); check("t2_dead_grant", grant, 2'b01);
    tk(); m0_if.cyc = 1; m0_if.stb = 1;
    smp(); check("t2_m1_grant", grant, 2'b10); check("t2_adr1", s_if.adr, 32'h200);
    check("t2_m1_cyc", s_if.cyc, 1);
    tk(); s_if.ack = 1;
    smp(); check("t2_m1_ack", m1_if.ack, 1); check("t2_m0_no_ack", m0_if.ack, 0);
    tk(); s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
    smp(); check("t2_dead2_cyc", s_if.cyc, 0); check("t2_dead2_grant", grant, 2'b10);
    tk(); smp(); check("t2_back_m0", grant, 2'b01);
    tk(); m0_if.cyc = 0; m0_if.stb = 0;
    tk(); m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
    smp(); check("t2_idle2", grant, 2'b00);
    tk(); smp(); check("t2_tie_m1", grant, 2'b10);
    tk(); m0_if.cyc = 0; m0_if.stb = 0; m1_if.cyc = 0; m1_if.stb = 0;
    tk(); smp(); check("t2_end_idle", grant, 2'b00);

    // 3: m0 8-beat incrementing burst, m1 requests at beat 3
    tk(); m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h1000; m0_if.cti = 3'b010;
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      tk();
      s_if.ack = 1; s_if.dat_r = 32'(i);
      m0_if.cti = (i == 7) ? 3'b111 : 3'b010;
      m0_if.adr = 32'h1000 + 32'(4 * i);
      if (i == 2) begin m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h2000; end
      smp();
      if (m0_if.ack) beats++;
      check($sformatf("t3_grant_b%0d", i), grant, 2'b01);
      check($sformatf("t3_m1_ack_b%0d", i), m1_if.ack, 0);
      check($sformatf("t3_cti_b%0d", i), s_if.cti, (i == 7) ? 3'b111 : 3'b010);
    end
    tk(); s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0; m0_if.cti = 3'b000;
    smp(); check("t3_beats", beats, 8); check("t3_dead_grant", grant, 2'b01);
    check("t3_dead_cyc", s_if.cyc, 0);
    tk(); smp(); check("t3_m1_grant", grant, 2'b10); check("t3_m1_adr", s_if.adr, 32'h2000);
    check("t3_m1_no_ack", m1_if.ack, 0);
    tk(); m1_if.cyc = 0; m1_if.stb = 0;
    tk(); smp(); check("t3_idle", grant, 2'b00);

    // 4: m1 stalls, watchdog fires 16 cycles after stb
    tk(); m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h3000;
    for (int k = 1; k < 16; k++) begin
      tk(); smp();
      if (k == 1) check("t4_grant", grant, 2'b10);
      check($sformatf("t4_no_err_%0d", k), m1_if.err, 0);
      check($sformatf("t4_no_to_%0d", k), timeout, 0);
    end
    tk(); smp();
    check("t4_err", m1_if.err, 1); check("t4_timeout", timeout, 1);
    check("t4_cyc_at_expiry", s_if.cyc, 1); check("t4_m0_err", m0_if.err, 0);
    tk(); smp();
    check("t4_err_pulse", m1_if.err, 0); check("t4_to_pulse", timeout, 0);
    check("t4_abort_cyc", s_if.cyc, 0); check("t4_abort_stb", s_if.stb, 0);
    tk(); smp(); check("t4_abort_hold", s_if.cyc, 0); check("t4_grant_hold", grant, 2'b10);
    tk(); m1_if.cyc = 0; m1_if.stb = 0;
    smp(); check("t4_drop_cyc", s_if.cyc, 0);
    tk(); smp(); check("t4_idle", grant, 2'b00);

    // 5: ack coincident with expiry, then reset mid-burst
    tk(); m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h4000; m0_if.cti = 3'b010;
    for (int k = 1; k < 16; k++) begin
      tk(); smp();
    end
    tk(); s_if.ack = 1;
    smp();
    check("t5_ack_wins", m0_if.ack, 1); check("t5_no_err", m0_if.err, 0);
    check("t5_no_timeout", timeout, 0);
    tk(); s_if.ack = 0;
    smp(); check("t5_no_err_after", m0_if.err, 0); check("t5_no_abort", s_if.cyc, 1);
    tk(); rst = 1'b1;
    smp(); check("t5_rst_same_cycle", s_if.cyc, 1);
    tk(); rst = 1'b0;
    smp();
    check("t5_rst_cyc", s_if.cyc, 0); check("t5_rst_stb", s_if.stb, 0);
    check("t5_rst_grant", grant, 2'b00); check("t5_rst_ack", m0_if.ack, 0);
    check("t5_rst_timeout", timeout, 0);
    tk(); smp(); check("t5_regrant", grant, 2'b01);
    tk(); m0_if.cyc = 0; m0_if.stb = 0;
    tk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
